ps2_frame_rx: RTL and testbench
===============================

// Module: ps2_frame_rx
// PURPOSE
//   Upstream stage of the keyboard path.
//   - Synchronises and debounces the raw PS/2 clock/data pins.
//   - Deframes 11-bit device-to-host frames: start, 8 data LSB-first, odd parity, stop.
//   - Presents each validated scan-code byte with a one-cycle strobe.
//   - Feeds the scan-code-to-ASCII translator, which in turn writes the keyboard buffer read by the CPU.
// PARAMETERS
//   CLK_FREQ        50000000  system clock frequency in Hz
//   DEBOUNCE_CYCLES 255       consecutive stable cycles needed before the filtered ps2 clock changes
//   TIMEOUT_US      2000      max gap between PS/2 clock falls inside a frame, in microseconds
// PORTS
//   clk         in   1  master clock; all state on rising edge
//   rst_n       in   1  asynchronous, active-low reset
//   ps2_clk     in   1  raw PS/2 clock pin (asynchronous)
//   ps2_data    in   1  raw PS/2 data pin (asynchronous)
//   code        out  8  last valid scan code; held until the next valid frame
//   code_valid  out  1  one-cycle pulse: code updated this cycle
//   parity_err  out  1  one-cycle pulse: frame dropped, parity mismatch
//   frame_err   out  1  one-cycle pulse: frame dropped, bad stop bit or timeout
//   busy        out  1  high while state != IDLE
// BEHAVIOUR
//   Reset:
//   - While rst_n=0: code=0, code_valid=0, parity_err=0, frame_err=0, busy=0, state=IDLE.
//   - Sync flops, filtered clock and its delayed copy reset to 1 (bus idle level).
//   Sync and filter:
//   - ps2_clk and ps2_data each pass through a 2-flop synchroniser.
//   - Filter counter clears whenever synced clk equals filtered clk.
//   - Otherwise it increments; on reaching DEBOUNCE_CYCLES the filtered clk takes the synced value and the counter clears.
//   - fall = filt_d & ~filt (registered edge detect). Synced data is sampled in the cycle fall=1.
//   FSM states and transitions (advance only on fall):
//   - IDLE: data=0 -> DATA with bit_cnt=0. data=1 -> stay IDLE, no error.
//   - DATA: shift data in LSB-first (shreg <= {data, shreg[7:1]}). bit_cnt 3 bits; after the 8th bit -> PARITY.
//   - PARITY: latch data as parity bit -> STOP.
//   - STOP, on fall, always -> IDLE; result decided in this priority:
//     - data=0: frame_err pulse; code unchanged.
//     - else ^{shreg, parity} == 0 (even, not odd): parity_err pulse; code unchanged.
//     - else: code <= shreg and code_valid pulse.
//   - Latency: the pulse is registered and asserts on the cycle after the stop-bit fall.
//   - At most one of code_valid/parity_err/frame_err is high in any cycle.
//   Timeout:
//   - TO_CYCLES = (CLK_FREQ/1000000)*TIMEOUT_US; counter width $clog2(TO_CYCLES+1).
//   - Counter clears in IDLE and on every fall.
//   - It increments in DATA/PARITY/STOP; on reaching TO_CYCLES: frame_err pulse, state -> IDLE.
//   - If fall and timeout coincide, fall wins: counter clears and the frame continues.
//   Reset mid-frame: the partial frame is discarded with no error pulse, and the next start bit opens a fresh frame.
//   Host-to-device (inhibit/transmit) is not supported; ps2_clk/ps2_data are inputs only.
// TESTING (bench sets DEBOUNCE_CYCLES=4, CLK_FREQ=1000000, TIMEOUT_US=100 -> TO_CYCLES=100;
//          PS/2 bit period 40 clk)
//   - Frame 0x1C, parity 0, stop 1 -> code=8'h1C, code_valid high exactly 1 cycle after the stop fall; busy back to 0.
//   - Frame 0x1C with parity 1 -> parity_err 1-cycle pulse, code_valid never high, code keeps its prior value.
//   - Frame 0xF0 with stop bit 0 -> frame_err pulse, code unchanged. A following good frame 0x5A -> code=8'h5A, code_valid.
//   - Glitches on ps2_clk: 2-cycle low pulses while idle, 3-cycle pulses mid-frame -> no fall detected, no state change.
//     Back-to-back frames 0x12 then 0xF0 then 0x12 -> three code_valid pulses in that order.
//   - Stop ps2_clk after 4 data bits -> frame_err pulse 100 clk after the last fall, busy=0.
//     A full frame 0x29 then follows -> code=8'h29.
//   - Assert rst_n=0 after 5 data bits -> all outputs 0 immediately (asynchronous), no error pulse after release.
//     Frame 0x66 next -> code=8'h66.

Source files
------------

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: PS/2 device-to-host frame receiver (clk in, rst_n async low; ps2_clk/ps2_data raw pins; code/code_valid/parity_err/frame_err/busy out)
module ps2_frame_rx #(
  parameter int CLK_FREQ        = 50000000,
  parameter int DEBOUNCE_CYCLES = 255,
  parameter int TIMEOUT_US      = 2000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);
  localparam int TO_CYCLES = (CLK_FREQ / 1000000) * TIMEOUT_US;
  localparam int TW = $clog2(TO_CYCLES + 1);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic [1:0] clk_s, dat_s;
  logic filt, filt_d, fall, timeout;
  logic [DW-1:0] deb_cnt;
  logic [TW-1:0] to_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic par, valid_n, perr_n, ferr_n;
  assign fall = filt_d & ~filt;
  assign timeout = (state != IDLE) && (to_cnt + 1'b1 == TW'(TO_CYCLES));
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s   <= 2'b11;
      dat_s   <= 2'b11;
      filt    <= 1'b1;
      filt_d  <= 1'b1;
      deb_cnt <= '0;
    end else begin
      clk_s   <= {clk_s[0], ps2_clk};
      dat_s   <= {dat_s[0], ps2_data};
      filt_d  <= filt;
      deb_cnt <= (clk_s[1] == filt || deb_cnt + 1'b1 == DW'(DEBOUNCE_CYCLES)) ? '0 : deb_cnt + 1'b1;
      if (clk_s[1] != filt && deb_cnt + 1'b1 == DW'(DEBOUNCE_CYCLES))
        filt <= clk_s[1];
    end
  end
  always_comb begin
    state_n = state;
    valid_n = 1'b0;
    perr_n  = 1'b0;
    ferr_n  = 1'b0;
    if (fall) begin
      case (state)
        IDLE:    state_n = dat_s[1] ? IDLE : DATA;
        DATA:    state_n = (bit_cnt == 3'd7) ? PARITY : DATA;
        PARITY:  state_n = STOP;
        default: begin
          state_n = IDLE;
          ferr_n  = ~dat_s[1];
          perr_n  = dat_s[1] & ~^{shreg, par};
          valid_n = dat_s[1] & ^{shreg, par};
        end
      endcase
    end else if (timeout) begin
      state_n = IDLE;
      ferr_n  = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      par        <= 1'b0;
      to_cnt     <= '0;
      code       <= '0;
      code_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      to_cnt     <= (state == IDLE || fall) ? '0 : to_cnt + 1'b1;
      code_valid <= valid_n;
      parity_err <= perr_n;
      frame_err  <= ferr_n;
      if (valid_n)
        code <= shreg;
      if (fall && state == IDLE)
        bit_cnt <= '0;
      if (fall && state == DATA) begin
        shreg   <= {dat_s[1], shreg[7:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (fall && state == PARITY)
        par <= dat_s[1];
    end
  end
endmodule

// File: tb/tb_ps2_frame_rx.sv
// tb_ps2_frame_rx: scoreboard bench for ps2_frame_rx
module tb_ps2_frame_rx;
  logic clk = 1'b0, rst_n = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic [7:0] code;
  logic code_valid, parity_err, frame_err, busy;
  typedef struct {int kind; logic [7:0] code;} ev_t;
  ev_t q[$];
  int total = 0, bad = 0, cyc = 0, ev_cyc = 0, last_drop = 0;
  logic [7:0] exp_code = 8'h00;
  ps2_frame_rx #(.CLK_FREQ(1000000), .DEBOUNCE_CYCLES(4), .TIMEOUT_US(100)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .code(code), .code_valid(code_valid), .parity_err(parity_err),
    .frame_err(frame_err), .busy(busy));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (rst_n && (code_valid || parity_err || frame_err)) begin
      ev_t e;
      int k;
      ev_cyc = cyc;
      k = code_valid ? 0 : parity_err ? 1 : 2;
      total++;
      if ($countones({code_valid, parity_err, frame_err}) != 1) begin
        bad++;
        $display("FAIL one_hot: got %b%b%b want exactly one", code_valid, parity_err, frame_err);
      end
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event: got kind %0d want none", k);
      end else begin
        e = q.pop_front();
        if (k !== e.kind) begin
          bad++;
          $display("FAIL event_kind: got %0d want %0d", k, e.kind);
        end
        if (e.kind == 0) exp_code = e.code;
      end
      total++;
      if (code !== exp_code) begin
        bad++;
        $display("FAIL event_code: got %h want %h", code, exp_code);
      end
    end
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send_bit(input logic b);
    ps2_data = b;
    tick(10);
    ps2_clk = 1'b0;
    last_drop = cyc;
    tick(20);
    ps2_clk = 1'b1;
    tick(10);
  endtask
  task automatic glitch(input int n);
    ps2_clk = 1'b0;
    tick(n);
    ps2_clk = 1'b1;
    tick(10);
  endtask
  task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic bad_stop, input int glitch_after);
    logic p;
    p = ~^d ^ bad_par;
    q.push_back('{bad_stop ? 2 : bad_par ? 1 : 0, d});
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      send_bit(d[i]);
      if (i == glitch_after) glitch(3);
    end
    send_bit(p);
    send_bit(~bad_stop);
    ps2_data = 1'b1;
    tick(20);
  endtask
  task automatic check_drained(input string name);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL %s_drained: got %0d pending want 0", name, q.size());
    end
  endtask
  task automatic test_reset();
    tick(3);
    total++;
    if ({code, code_valid, parity_err, frame_err, busy} !== 12'h0) begin
      bad++;
      $display("FAIL reset_outputs: got %h/%b%b%b%b want 00/0000", code, code_valid, parity_err, frame_err, busy);
    end
    rst_n = 1'b1;
    tick(5);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_busy: got %b want 0", busy);
    end
  endtask
  task automatic test_good_frame();
    send_frame(8'h1C, 1'b0, 1'b0, -1);
    check_drained("good");
    total++;
    if (ev_cyc - last_drop != 7) begin
      bad++;
      $display("FAIL good_latency: got %0d want 7", ev_cyc - last_drop);
    end
    total++;
    if (code !== 8'h1C || busy !== 1'b0) begin
      bad++;
      $display("FAIL good_code_busy: got %h/%b want 1c/0", code, busy);
    end
  endtask
  task automatic test_parity();
    send_frame(8'h1C, 1'b1, 1'b0, -1);
    check_drained("parity");
    total++;
    if (code !== 8'h1C) begin
      bad++;
      $display("FAIL parity_code_kept: got %h want 1c", code);
    end
  endtask
  task automatic test_stop_bit();
    send_frame(8'hF0, 1'b0, 1'b1, -1);
    check_drained("stop");
    send_frame(8'h5A, 1'b0, 1'b0, -1);
    check_drained("after_stop");
    total++;
    if (code !== 8'h5A) begin
      bad++;
      $display("FAIL after_stop_code: got %h want 5a", code);
    end
  endtask
  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      ps2_clk = 1'b0;
      tick(2);
      ps2_clk = 1'b1;
      tick(10);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_glitch_busy: got %b want 0", busy);
    end
    send_frame(8'h12, 1'b0, 1'b0, 3);
    send_frame(8'hF0, 1'b0, 1'b0, 5);
    send_frame(8'h12, 1'b0, 1'b0, -1);
    check_drained("b2b");
    total++;
    if (code !== 8'h12) begin
      bad++;
      $display("FAIL b2b_code: got %h want 12", code);
    end
  endtask
  task automatic test_timeout();
    q.push_back('{2, 8'h00});
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL timeout_busy_mid: got %b want 1", busy);
    end
    ps2_data = 1'b1;
    tick(120);
    check_drained("timeout");
    total++;
    if (ev_cyc - last_drop != 107 || busy !== 1'b0) begin
      bad++;
      $display("FAIL timeout_delay_busy: got %0d/%b want 107/0", ev_cyc - last_drop, busy);
    end
    send_frame(8'h29, 1'b0, 1'b0, -1);
    check_drained("after_timeout");
    total++;
    if (code !== 8'h29) begin
      bad++;
      $display("FAIL after_timeout_code: got %h want 29", code);
    end
  endtask
  task automatic test_reset_mid_frame();
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(i[0]);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL midrst_busy_before: got %b want 1", busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    exp_code = 8'h00;
    total++;
    if ({code, code_valid, parity_err, frame_err, busy} !== 12'h0) begin
      bad++;
      $display("FAIL midrst_outputs: got %h/%b%b%b%b want 00/0000", code, code_valid, parity_err, frame_err, busy);
    end
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    tick(5);
    rst_n = 1'b1;
    tick(150);
    check_drained("midrst_quiet");
    send_frame(8'h66, 1'b0, 1'b0, -1);
    check_drained("after_midrst");
    total++;
    if (code !== 8'h66) begin
      bad++;
      $display("FAIL after_midrst_code: got %h want 66", code);
    end
  endtask
  initial begin
    test_reset();
    test_good_frame();
    test_parity();
    test_stop_bit();
    test_back_to_back();
    test_timeout();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
